keypad_matrix_scanner: RTL and testbench

- Scans a 4x4 active-low matrix keypad and emits one debounced key event per physical press as a 4-bit code plus a single-cycle valid pulse.
- Acts as the producer side of the lock's entry interface. It replaces the fixed switch and confirm-key inputs with keypad-entered digits.
- Sits between the keypad pins and the lock / password-entry logic, in the same clock domain.

---
 rtl/keypad_matrix_scanner.sv | 148 ++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x4 active-low keypad and emits one
// debounced event per physical press.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   row_in    keypad rows, pulled up; low = key closed in driven column
//   col_out   active-low one-hot column drive
//   key_code  {row[1:0], col[1:0]} of the last accepted key, held
//   key_valid one-cycle pulse when key_code updates
//   key_held  high from acceptance until a debounced release
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HOLD
    } state_t;

    state_t state;

    logic [3:0]    sync1;
    logic [3:0]    rows_s;
    logic [DW-1:0] divider;
    logic          tick;
    logic [1:0]    col_idx;
    logic [1:0]    col_nxt;
    logic [3:0]    col_nxt_pat;
    logic [1:0]    cand_row;
    logic [1:0]    cand_col;
    logic [3:0]    stable_cnt;
    logic [3:0]    cnt_inc;

    logic          idle;
    logic          single;
    logic [1:0]    low_row;

    assign tick        = (divider == DIV_LAST);
    assign col_nxt     = col_idx + 2'd1;
    assign col_nxt_pat = ~(4'b0001 << col_nxt);
    assign cnt_inc     = stable_cnt + 4'd1;

    // Two or more low rows in one column is ghosting and never
    // counts as a key, so only exact one-low patterns decode.
    always_comb begin
        idle    = (rows_s == 4'b1111);
        single  = 1'b0;
        low_row = 2'd0;
        unique case (rows_s)
            4'b1110: begin single = 1'b1; low_row = 2'd0; end
            4'b1101: begin single = 1'b1; low_row = 2'd1; end
            4'b1011: begin single = 1'b1; low_row = 2'd2; end
            4'b0111: begin single = 1'b1; low_row = 2'd3; end
            default: begin single = 1'b0; low_row = 2'd0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 4'b1111;
            rows_s     <= 4'b1111;
            divider    <= '0;
            col_idx    <= 2'd0;
            col_out    <= 4'b1110;
            cand_row   <= 2'd0;
            cand_col   <= 2'd0;
            stable_cnt <= 4'd0;
            key_code   <= 4'd0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
            state      <= SCAN;
        end else begin
            sync1     <= row_in;
            rows_s    <= sync1;
            divider   <= tick ? '0 : divider + 1'b1;
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (single) begin
                            cand_row   <= low_row;
                            cand_col   <= col_idx;
                            stable_cnt <= 4'd1;
                            state      <= CONFIRM;
                        end else begin
                            col_idx <= col_nxt;
                            col_out <= col_nxt_pat;
                        end
                    end
                    CONFIRM: begin
                        if (single && low_row == cand_row) begin
                            if (cnt_inc == DEB) begin
                                key_code   <= {cand_row, cand_col};
                                key_valid  <= 1'b1;
                                key_held   <= 1'b1;
                                stable_cnt <= 4'd0;
                                state      <= HOLD;
                            end else begin
                                stable_cnt <= cnt_inc;
                            end
                        end else begin
                            stable_cnt <= 4'd0;
                            state      <= SCAN;
                            col_idx    <= col_nxt;
                            col_out    <= col_nxt_pat;
                        end
                    end
                    HOLD: begin
                        // Any low row, including a second key, restarts
                        // the release count; no repeat events here.
                        if (idle) begin
                            if (cnt_inc == DEB) begin
                                key_held   <= 1'b0;
                                stable_cnt <= 4'd0;
                                state      <= SCAN;
                                col_idx    <= col_nxt;
                                col_out    <= col_nxt_pat;
                            end else begin
                                stable_cnt <= cnt_inc;
                            end
                        end else begin
                            stable_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: keypad model driving the scanner, with a
// scoreboard of expected key codes and a table of key presses.
module tb_keypad_matrix_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          tb_div;

    typedef struct {
        int         row;
        int         col;
        int         hold;
        logic [3:0] code;
    } key_vec_t;

    key_vec_t vecs[5];

    keypad_matrix_scanner #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c])
                    row_in[r] = 1'b0;
    end

    // Phase of the scan divider; 0 just after a tick edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_div <= 0;
        else tb_div <= (tb_div == SD - 1) ? 0 : tb_div + 1;
    end

    function automatic logic [3:0] col_pat(input int c);
        return ~(4'b0001 << (c % 4));
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (key_valid) begin
                if (prev) check("valid_twice", 32'd1, 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: code %h at %0t",
                             key_code, $time);
                end else begin
                    check("sb_code", key_code, exp_q.pop_front());
                end
            end
            prev = key_valid;
        end
    endtask

    task automatic wait_enter(input int c);
        logic [3:0] prev;
        bit hit;
        prev = col_out;
        hit = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (col_out == col_pat(c) && prev != col_pat(c)) begin
                hit = 1;
                break;
            end
            prev = col_out;
        end
        check("enter_col", 32'(hit), 32'd1);
    endtask

    task automatic wait_held_low(input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (!key_held) begin
                hit = 1;
                break;
            end
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic run_key(input key_vec_t v);
        wait_enter(v.col);
        exp_q.push_back(v.code);
        pressed[v.row*4+v.col] = 1'b1;
        repeat (11) @(negedge clk);
        check("press_early", 32'(key_valid), 32'd0);
        check("held_early", 32'(key_held), 32'd0);
        @(negedge clk);
        check("press_valid", 32'(key_valid), 32'd1);
        check("press_code", 32'(key_code), 32'(v.code));
        check("press_held", 32'(key_held), 32'd1);
        check("col_frozen", 32'(col_out), 32'(col_pat(v.col)));
        repeat (v.hold) @(negedge clk);
        check("hold_held", 32'(key_held), 32'd1);
        check("hold_col", 32'(col_out), 32'(col_pat(v.col)));
        for (int i = 0; i < SD; i++) begin
            if (tb_div == 0) break;
            @(negedge clk);
        end
        pressed[v.row*4+v.col] = 1'b0;
        repeat (11) @(negedge clk);
        check("release_early", 32'(key_held), 32'd1);
        @(negedge clk);
        check("release", 32'(key_held), 32'd0);
        check("resume_col", 32'(col_out), 32'(col_pat(v.col + 1)));
    endtask

    initial begin
        bit hit;
        vecs[0] = '{2, 1, 20, 4'h9};
        vecs[1] = '{3, 3, 200, 4'hF};
        vecs[2] = '{0, 2, 20, 4'h2};
        vecs[3] = '{1, 0, 20, 4'h4};
        vecs[4] = '{3, 2, 8, 4'hE};

        pressed = '0;
        rst = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_out), 32'hE);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("scan_col", 32'(col_out), 32'(col_pat(k / 4)));
        end

        foreach (vecs[i]) run_key(vecs[i]);

        // One-tick glitch in column 3: no event, scan resumes at col 0.
        wait_enter(3);
        pressed[0*4+3] = 1'b1;
        repeat (5) @(negedge clk);
        pressed[0*4+3] = 1'b0;
        repeat (2) @(negedge clk);
        check("glitch_col3", 32'(col_out), 32'h7);
        @(negedge clk);
        check("glitch_col0", 32'(col_out), 32'hE);
        check("glitch_code", 32'(key_code), 32'hE);
        check("glitch_held", 32'(key_held), 32'd0);

        // Ghosting: rows 1 and 3 in column 0 never stop the scan.
        wait_enter(0);
        pressed[1*4+0] = 1'b1;
        pressed[3*4+0] = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            repeat (4) @(negedge clk);
            check("ghost_col", 32'(col_out), 32'(col_pat(j)));
        end
        pressed = '0;
        repeat (16) @(negedge clk);
        check("ghost_held", 32'(key_held), 32'd0);

        // Second key in the frozen column while holding is ignored.
        wait_enter(3);
        exp_q.push_back(4'hB);
        pressed[2*4+3] = 1'b1;
        repeat (12) @(negedge clk);
        check("second_first", 32'(key_valid), 32'd1);
        repeat (6) @(negedge clk);
        pressed[0*4+3] = 1'b1;
        repeat (40) @(negedge clk);
        pressed[0*4+3] = 1'b0;
        repeat (20) @(negedge clk);
        check("second_held", 32'(key_held), 32'd1);
        pressed[2*4+3] = 1'b0;
        wait_held_low("second_release");

        // Reset during HOLD, then re-detect the still-pressed key.
        wait_enter(1);
        exp_q.push_back(4'h5);
        pressed[1*4+1] = 1'b1;
        repeat (12) @(negedge clk);
        check("rh_valid", 32'(key_valid), 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rh_held", 32'(key_held), 32'd0);
        check("rh_code", 32'(key_code), 32'h0);
        check("rh_col", 32'(col_out), 32'hE);
        check("rh_valid0", 32'(key_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(4'h5);
        hit = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (key_valid) begin
                hit = 1;
                break;
            end
        end
        check("redetect", 32'(hit), 32'd1);
        pressed = '0;
        wait_held_low("redetect_release");

        repeat (20) @(negedge clk);
        check("sb_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
